// File: rtl/gps_pkg.sv
// Shared types and defaults for the GPS point feeder.
package gps_pkg;
   localparam int GPS_COORD_W = 24;
   localparam int GPS_GAP_MIN = 2;
   localparam int GPS_TIMEOUT = 1024;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_V, GAP} gps_state_e;
endpackage

// File: rtl/gps_fifo.sv
// Synchronous FIFO with push/pop/flush; occupancy comes from a count register.
module gps_fifo #(
   parameter int W     = 48,
   parameter int DEPTH = 8,
   parameter int AW    = 3
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [AW:0]   level,
   output logic          full
);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [AW:0]   r_cnt;

   always_ff @(posedge clk) begin
      if (push && !flush) r_mem[r_wr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else if (flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (push) r_wr <= r_wr + 1'b1;
         if (pop)  r_rd <= r_rd + 1'b1;
         case ({push, pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign rdata = r_mem[r_rd];
   assign level = r_cnt;
   assign full  = (r_cnt == (AW+1)'(DEPTH));
endmodule

// File: rtl/gps_point_feeder.sv
// Feeds buffered LON/LAT points to the distance calculator, paced by its Valid.
// Optional watchdog on the Valid wait is enabled by defining GPS_WDOG_EN.
module gps_point_feeder
   import gps_pkg::*;
#(
   parameter int COORD_W = GPS_COORD_W,
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int GAP_MIN = GPS_GAP_MIN
`ifdef GPS_WDOG_EN
   ,parameter int TIMEOUT = GPS_TIMEOUT
`endif
)(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [COORD_W-1:0] in_lon,
   input  logic [COORD_W-1:0] in_lat,
   input  logic               flush,
   input  logic               gps_valid,
   output logic               DEN,
   output logic [COORD_W-1:0] LON_OUT,
   output logic [COORD_W-1:0] LAT_OUT,
   output logic [AW:0]        level,
   output logic [15:0]        issued_cnt,
   output logic               timeout
);
   localparam int GW = (GAP_MIN > 1) ? $clog2(GAP_MIN) : 1;

   gps_state_e           r_state, w_nxt;
   logic [2*COORD_W-1:0] w_head;
   logic [AW:0]          w_level;
   logic                 w_full, w_push, w_pop, w_go;
   logic                 r_den, r_primed;
   logic [COORD_W-1:0]   r_lon, r_lat;
   logic [15:0]          r_issued;
   logic [GW-1:0]        r_gap;

   assign in_ready = !w_full && !flush;
   assign w_push   = in_valid && in_ready;
   // A flush in the deciding cycle would empty the FIFO under a pending pop.
   assign w_go     = (w_level != '0) && !flush;

   gps_fifo #(.W(2*COORD_W), .DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk(clk), .reset_n(reset_n), .push(w_push), .pop(w_pop), .flush(flush),
      .wdata({in_lon, in_lat}), .rdata(w_head), .level(w_level), .full(w_full)
   );

`ifdef GPS_WDOG_EN
   localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [WDW-1:0] r_wd;
   logic           r_timeout, w_to, w_wd_exp;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wd      <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_wd      <= (r_state == WAIT_V) ? r_wd + 1'b1 : '0;
         r_timeout <= w_to;
      end
   end
   assign w_wd_exp = (r_wd == WDW'(TIMEOUT-1));
   assign w_to     = (r_state == WAIT_V) && !gps_valid && w_wd_exp;
   assign timeout  = r_timeout;
`else
   assign timeout  = 1'b0;
`endif

   always_comb begin
      w_nxt = r_state;
      w_pop = 1'b0;
      case (r_state)
         IDLE:   if (w_go) w_nxt = ISSUE;
         ISSUE: begin
            w_pop = 1'b1;
            w_nxt = r_primed ? WAIT_V : GAP;
         end
`ifdef GPS_WDOG_EN
         WAIT_V: if (gps_valid || w_wd_exp) w_nxt = GAP;
`else
         WAIT_V: if (gps_valid) w_nxt = GAP;
`endif
         // GAP falls straight into ISSUE so DEN spacing is exactly GAP_MIN+1.
         GAP:    if (r_gap == GW'(GAP_MIN-1)) w_nxt = w_go ? ISSUE : IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_den    <= 1'b0;
         r_primed <= 1'b0;
         r_lon    <= '0;
         r_lat    <= '0;
         r_issued <= '0;
         r_gap    <= '0;
      end else begin
         r_state <= w_nxt;
         r_den   <= (r_state == ISSUE);
         r_gap   <= (r_state == GAP) ? r_gap + 1'b1 : '0;
         if (r_state == ISSUE) begin
            {r_lon, r_lat} <= w_head;
            r_issued       <= r_issued + 16'd1;
            r_primed       <= 1'b1;
         end
      end
   end

   assign DEN        = r_den;
   assign LON_OUT    = r_lon;
   assign LAT_OUT    = r_lat;
   assign level      = w_level;
   assign issued_cnt = r_issued;
endmodule

// File: tb/tb_gps_point_feeder.sv
// Directed self-checking bench for gps_point_feeder.
module tb_gps_point_feeder;
   localparam int GAP_MIN = 2;

   logic        clk, reset_n, in_valid, flush, gps_valid;
   logic        in_ready, DEN, timeout;
   logic [23:0] in_lon, in_lat, LON_OUT, LAT_OUT;
   logic [3:0]  level;
   logic [15:0] issued_cnt;

   int n_vec = 0, n_err = 0, cyc = 0, src_i = 0;

`ifdef GPS_WDOG_EN
   gps_point_feeder #(.COORD_W(24), .DEPTH(8), .AW(3), .GAP_MIN(GAP_MIN), .TIMEOUT(16)) dut (
`else
   gps_point_feeder #(.COORD_W(24), .DEPTH(8), .AW(3), .GAP_MIN(GAP_MIN)) dut (
`endif
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_lon(in_lon), .in_lat(in_lat), .flush(flush), .gps_valid(gps_valid),
      .DEN(DEN), .LON_OUT(LON_OUT), .LAT_OUT(LAT_OUT), .level(level),
      .issued_cnt(issued_cnt), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [23:0] lon, input logic [23:0] lat);
      in_valid = 1'b1; in_lon = lon; in_lat = lat;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_den(output int c, output bit ok);
      ok = 1'b0; c = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         step();
         if (DEN === 1'b1) begin ok = 1'b1; c = cyc; end
      end
      if (!ok) begin
         n_vec++; n_err++;
         $display("FAIL den_wait: no DEN within 100 cycles");
      end
   endtask

   task automatic pulse_valid;
      gps_valid = 1'b1;
      step();
      gps_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      #12;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
      @(negedge clk); reset_n = 1'b1;
      repeat (10) step();
      n_vec++; if (DEN !== 1'b0) begin n_err++; $display("FAIL rst_den got %b want 0", DEN); end
      n_vec++; if (LON_OUT !== 24'h0) begin n_err++; $display("FAIL rst_lon got %h want 0", LON_OUT); end
      n_vec++; if (LAT_OUT !== 24'h0) begin n_err++; $display("FAIL rst_lat got %h want 0", LAT_OUT); end
      n_vec++; if (level !== 4'd0) begin n_err++; $display("FAIL rst_level got %0d want 0", level); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
      n_vec++; if (issued_cnt !== 16'd0) begin n_err++; $display("FAIL rst_issued got %0d want 0", issued_cnt); end
      n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout got %b want 0", timeout); end
   endtask

   task automatic test_two_points;
      int a, c1, c2, nd; bit ok;
      push(24'h123456, 24'h654321);
      a = cyc;
      push(24'h111111, 24'h222222);
      wait_den(c1, ok);
      if (ok) begin
         n_vec++; if (c1 - a != 2) begin n_err++; $display("FAIL den1_latency got %0d want 2", c1 - a); end
         n_vec++; if (LON_OUT !== 24'h123456) begin n_err++; $display("FAIL den1_lon got %h want 123456", LON_OUT); end
         n_vec++; if (LAT_OUT !== 24'h654321) begin n_err++; $display("FAIL den1_lat got %h want 654321", LAT_OUT); end
      end
      step();
      n_vec++; if (DEN !== 1'b0) begin n_err++; $display("FAIL den1_width got %b want 0", DEN); end
      wait_den(c2, ok);
      if (ok) begin
         n_vec++; if (c2 - c1 != GAP_MIN + 1) begin n_err++; $display("FAIL den2_spacing got %0d want %0d", c2 - c1, GAP_MIN + 1); end
         n_vec++; if (LON_OUT !== 24'h111111) begin n_err++; $display("FAIL den2_lon got %h want 111111", LON_OUT); end
      end
      nd = 0;
      repeat (10) begin step(); if (DEN === 1'b1) nd++; end
      n_vec++; if (nd != 0) begin n_err++; $display("FAIL waitv_hold got %0d DENs want 0", nd); end
      n_vec++; if (issued_cnt !== 16'd2) begin n_err++; $display("FAIL issued_2 got %0d want 2", issued_cnt); end
   endtask

   task automatic test_valid_pacing;
      int t, c; bit ok;
      push(24'h333333, 24'h444444);
      repeat (3) step();
      n_vec++; if (level !== 4'd1) begin n_err++; $display("FAIL pace_level got %0d want 1", level); end
      t = cyc;
      pulse_valid();
      wait_den(c, ok);
      if (ok) begin
         n_vec++; if (c != t + GAP_MIN + 2) begin n_err++; $display("FAIL den3_time got %0d want %0d", c - t, GAP_MIN + 2); end
         n_vec++; if (LON_OUT !== 24'h333333) begin n_err++; $display("FAIL den3_lon got %h want 333333", LON_OUT); end
      end
      n_vec++; if (issued_cnt !== 16'd3) begin n_err++; $display("FAIL issued_3 got %0d want 3", issued_cnt); end
   endtask

   task automatic test_full;
      fork
         begin
            int g; bit acc;
            g = 0; src_i = 0;
            while (src_i < 10 && g < 600) begin
               in_valid = 1'b1;
               in_lon = 24'h500000 + 24'(src_i);
               in_lat = 24'hA00000 + 24'(src_i);
               acc = in_ready;
               @(posedge clk);
               if (acc) src_i++;
               @(negedge clk);
               g++;
            end
            in_valid = 1'b0;
         end
         begin
            int c; bit ok;
            repeat (20) step();
            n_vec++; if (level !== 4'd8) begin n_err++; $display("FAIL full_level got %0d want 8", level); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %b want 0", in_ready); end
            n_vec++; if (src_i != 8) begin n_err++; $display("FAIL full_accepted got %0d want 8", src_i); end
            for (int j = 0; j < 10; j++) begin
               pulse_valid();
               wait_den(c, ok);
               if (ok) begin
                  n_vec++;
                  if (LON_OUT !== 24'h500000 + 24'(j)) begin
                     n_err++; $display("FAIL drain_lon[%0d] got %h want %h", j, LON_OUT, 24'h500000 + 24'(j));
                  end
               end
            end
         end
      join
      n_vec++; if (issued_cnt !== 16'd13) begin n_err++; $display("FAIL issued_13 got %0d want 13", issued_cnt); end
   endtask

   task automatic test_flush;
      int nd;
      for (int k = 0; k < 5; k++) push(24'h600000 + 24'(k), 24'h0);
      n_vec++; if (level !== 4'd5) begin n_err++; $display("FAIL flush_pre_level got %0d want 5", level); end
      in_valid = 1'b1; in_lon = 24'h6F0000; in_lat = 24'h0; flush = 1'b1;
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      n_vec++; if (level !== 4'd0) begin n_err++; $display("FAIL flush_level got %0d want 0", level); end
      pulse_valid();
      nd = 0;
      repeat (15) begin step(); if (DEN === 1'b1) nd++; end
      n_vec++; if (nd != 0) begin n_err++; $display("FAIL flush_no_den got %0d DENs want 0", nd); end
      n_vec++; if (issued_cnt !== 16'd13) begin n_err++; $display("FAIL flush_issued got %0d want 13", issued_cnt); end
   endtask

   task automatic test_reset_midwait;
      int c; bit ok;
      push(24'h777777, 24'h888888);
      wait_den(c, ok);
      n_vec++; if (LON_OUT !== 24'h777777) begin n_err++; $display("FAIL mid_lon_pre got %h want 777777", LON_OUT); end
      push(24'h700001, 24'h0);
      push(24'h700002, 24'h0);
      #2 reset_n = 1'b0;
      #1;
      n_vec++; if (LON_OUT !== 24'h0) begin n_err++; $display("FAIL mid_rst_lon got %h want 0", LON_OUT); end
      n_vec++; if (LAT_OUT !== 24'h0) begin n_err++; $display("FAIL mid_rst_lat got %h want 0", LAT_OUT); end
      n_vec++; if (level !== 4'd0) begin n_err++; $display("FAIL mid_rst_level got %0d want 0", level); end
      n_vec++; if (issued_cnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_issued got %0d want 0", issued_cnt); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready got %b want 1", in_ready); end
      n_vec++; if (DEN !== 1'b0 || timeout !== 1'b0) begin n_err++; $display("FAIL mid_rst_den_to got %b%b want 00", DEN, timeout); end
      @(negedge clk); reset_n = 1'b1;
      step();
   endtask

`ifdef GPS_WDOG_EN
   task automatic test_watchdog;
      int c1, c2, c3, x; bit ok, seen;
      push(24'h010101, 24'h0);
      push(24'h020202, 24'h0);
      push(24'h030303, 24'h0);
      wait_den(c1, ok);
      wait_den(c2, ok);
      seen = 1'b0; x = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         if (timeout === 1'b1) begin seen = 1'b1; x = cyc; end
      end
      n_vec++; if (!seen) begin n_err++; $display("FAIL wdog_seen got 0 want 1"); end
      n_vec++; if (x - c2 != 16) begin n_err++; $display("FAIL wdog_time got %0d want 16", x - c2); end
      step();
      n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL wdog_width got %b want 0", timeout); end
      wait_den(c3, ok);
      if (ok) begin
         n_vec++; if (c3 - x != GAP_MIN + 1) begin n_err++; $display("FAIL wdog_next_den got %0d want %0d", c3 - x, GAP_MIN + 1); end
         n_vec++; if (LON_OUT !== 24'h030303) begin n_err++; $display("FAIL wdog_next_lon got %h want 030303", LON_OUT); end
      end
   endtask
`endif

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; gps_valid = 1'b0;
      in_lon = '0; in_lat = '0;
      test_reset();
      test_two_points();
      test_valid_pacing();
      test_full();
      test_flush();
      test_reset_midwait();
`ifdef GPS_WDOG_EN
      test_watchdog();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1);
   end
endmodule
